// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, Set-2 make codes, break prefix
// and the hex-to-make-code lookup also used by the decoder-side bench.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BIT_HI,
        BIT_LO,
        GAP,
        NEXT
    } ps2_tx_state_t;

    localparam logic [7:0] SET2_KEY_0 = 8'h45;
    localparam logic [7:0] SET2_KEY_1 = 8'h16;
    localparam logic [7:0] SET2_KEY_2 = 8'h1E;
    localparam logic [7:0] SET2_KEY_3 = 8'h26;
    localparam logic [7:0] SET2_KEY_4 = 8'h25;
    localparam logic [7:0] SET2_KEY_5 = 8'h2E;
    localparam logic [7:0] SET2_KEY_6 = 8'h36;
    localparam logic [7:0] SET2_KEY_7 = 8'h3D;
    localparam logic [7:0] SET2_KEY_8 = 8'h3E;
    localparam logic [7:0] SET2_KEY_9 = 8'h46;
    localparam logic [7:0] SET2_KEY_A = 8'h1C;
    localparam logic [7:0] SET2_KEY_B = 8'h32;
    localparam logic [7:0] SET2_KEY_C = 8'h21;
    localparam logic [7:0] SET2_KEY_D = 8'h23;
    localparam logic [7:0] SET2_KEY_E = 8'h24;
    localparam logic [7:0] SET2_KEY_F = 8'h2B;

    localparam logic [7:0] BREAK_PREFIX   = 8'hF0;
    localparam int         FRAME_LAST_BIT = 10;

    function automatic logic [7:0] hex_to_set2(input logic [3:0] key);
        logic [7:0] code;
        code = 8'h00;
        case (key)
            4'h0: code = SET2_KEY_0;
            4'h1: code = SET2_KEY_1;
            4'h2: code = SET2_KEY_2;
            4'h3: code = SET2_KEY_3;
            4'h4: code = SET2_KEY_4;
            4'h5: code = SET2_KEY_5;
            4'h6: code = SET2_KEY_6;
            4'h7: code = SET2_KEY_7;
            4'h8: code = SET2_KEY_8;
            4'h9: code = SET2_KEY_9;
            4'hA: code = SET2_KEY_A;
            4'hB: code = SET2_KEY_B;
            4'hC: code = SET2_KEY_C;
            4'hD: code = SET2_KEY_D;
            4'hE: code = SET2_KEY_E;
            4'hF: code = SET2_KEY_F;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/ps2_frame_shift.sv
// Holds one 11-bit PS/2 frame (start, 8 data LSB first, odd parity, stop)
// and exposes the bit that will be presented after the next shift.
module ps2_frame_shift (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       load,
    input  logic [7:0] data,
    input  logic       shift,
    output logic       next_bit
);

    logic [10:0] frame;

    // Stop-bit ones fill in from the top so an exhausted frame reads idle-high.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            frame <= '1;
        end else if (load) begin
            frame <= {1'b1, ~^data, data, 1'b0};
        end else if (shift) begin
            frame <= {1'b1, frame[10:1]};
        end
    end

    assign next_bit = frame[1];

endmodule

// File: rtl/ps2_keycode_tx.sv
// Hex key to PS/2 Set-2 make code encoder and device-to-host frame transmitter.
// Define PS2_KEYCODE_TX_BREAK_EN to send make, F0, make for every key.
module ps2_keycode_tx
    import ps2_pkg::*;
#(
    parameter int CLK_DIV = 2500,
    parameter int GAP_CYC = 5000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] key_in,
    input  logic       key_valid,
    output logic       key_ready,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy,
    output logic       done,
    output logic [7:0] code_out
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int GAP_W = $clog2(GAP_CYC + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

    ps2_tx_state_t    state, next_state;
    logic [DIV_W-1:0] div_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [GAP_W-1:0] gap_limit;
    logic [3:0]       bit_idx;
    logic [7:0]       load_byte;
    logic             accept, load, shift, more;
    logic             div_last, gap_last, frame_bit;

`ifdef PS2_KEYCODE_TX_BREAK_EN
    // Inter-byte gaps give one cycle to NEXT so every byte slot stays the same length.
    localparam logic [GAP_W-1:0] GAP_SHORT = GAP_W'((GAP_CYC > 1) ? GAP_CYC - 2 : 0);
    logic [1:0] byte_idx;

    assign more      = (byte_idx != 2'd2);
    assign gap_limit = more ? GAP_SHORT : GAP_LAST;
`else
    assign more      = 1'b0;
    assign gap_limit = GAP_LAST;
`endif

    assign div_last = (div_cnt == DIV_LAST);
    assign gap_last = (gap_cnt == gap_limit);

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        load       = 1'b0;
        shift      = 1'b0;
        load_byte  = hex_to_set2(key_in);
        case (state)
            IDLE: begin
                if (key_valid) begin
                    accept     = 1'b1;
                    load       = 1'b1;
                    next_state = BIT_HI;
                end
            end
            BIT_HI: begin
                if (div_last) next_state = BIT_LO;
            end
            BIT_LO: begin
                if (div_last) begin
                    if (bit_idx == 4'(FRAME_LAST_BIT)) begin
                        next_state = GAP;
                    end else begin
                        shift      = 1'b1;
                        next_state = BIT_HI;
                    end
                end
            end
            GAP: begin
                if (gap_last) next_state = more ? NEXT : IDLE;
            end
            NEXT: begin
                load       = 1'b1;
`ifdef PS2_KEYCODE_TX_BREAK_EN
                load_byte  = (byte_idx == 2'd1) ? BREAK_PREFIX : code_out;
`else
                load_byte  = code_out;
`endif
                next_state = BIT_HI;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            div_cnt <= '0;
            gap_cnt <= '0;
            bit_idx <= '0;
        end else begin
            state <= next_state;
            if (next_state != state) begin
                div_cnt <= '0;
                gap_cnt <= '0;
            end else begin
                if (state == BIT_HI || state == BIT_LO) div_cnt <= div_cnt + 1'b1;
                if (state == GAP) gap_cnt <= gap_cnt + 1'b1;
            end
            if (load) begin
                bit_idx <= '0;
            end else if (shift) begin
                bit_idx <= bit_idx + 4'd1;
            end
        end
    end

    // Outputs follow next_state so each one is a flop aligned with the state register.
    // ps2_data only moves on entry to BIT_HI; a load always presents the start bit.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ps2_clk   <= 1'b1;
            ps2_data  <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            key_ready <= 1'b1;
            code_out  <= 8'h00;
        end else begin
            ps2_clk   <= (next_state != BIT_LO);
            busy      <= (next_state != IDLE);
            key_ready <= (next_state == IDLE);
            done      <= (state == GAP) && (next_state == IDLE);
            if (load) begin
                ps2_data <= 1'b0;
            end else if (shift) begin
                ps2_data <= frame_bit;
            end
            if (accept) code_out <= hex_to_set2(key_in);
        end
    end

`ifdef PS2_KEYCODE_TX_BREAK_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            byte_idx <= '0;
        end else if (accept) begin
            byte_idx <= '0;
        end else if (state == GAP && next_state == NEXT) begin
            byte_idx <= byte_idx + 2'd1;
        end
    end
`endif

    ps2_frame_shift u_frame_shift (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .load     (load),
        .data     (load_byte),
        .shift    (shift),
        .next_bit (frame_bit)
    );

endmodule
